// File: rtl/mp3_display_pkg.sv
// Shared 640x480@60 raster timing for the mp3_display path.
// The colouriser and the timing generator both take their resolution from here,
// so the coordinate ranges they agree on can never drift apart.
package mp3_display_pkg;

    // Signed raster coordinate: negative during blanking, 0..RES-1 when active.
    typedef logic signed [15:0] coord_t;

    localparam int TIMING_H_RES  = 640;
    localparam int TIMING_H_FP   = 16;
    localparam int TIMING_H_SYNC = 96;
    localparam int TIMING_H_BP   = 48;
    localparam int TIMING_V_RES  = 480;
    localparam int TIMING_V_FP   = 10;
    localparam int TIMING_V_SYNC = 2;
    localparam int TIMING_V_BP   = 33;

    // Sync pulses are active-low for the standard VGA mode.
    localparam bit TIMING_H_POL = 1'b0;
    localparam bit TIMING_V_POL = 1'b0;

    // A span is legal when every part is positive and the whole span fits a signed 16-bit coordinate.
    function automatic bit span_ok(input int res, input int fp, input int sync, input int bp);
        return (res > 0) && (fp > 0) && (sync > 0) && (bp > 0) &&
               ((res + fp + sync + bp) < 32768);
    endfunction

    // First coordinate of a span: blanking is counted as negative positions before pixel 0.
    function automatic coord_t span_start(input int fp, input int sync, input int bp);
        return coord_t'(-(fp + sync + bp));
    endfunction

endpackage

// File: rtl/mp3_span_counter.sv
// Signed position counter that walks START..END and wraps back to START.
// Used once for columns and once for rows of the raster.
module mp3_span_counter
    import mp3_display_pkg::*;
#(
    parameter coord_t START = -16'sd160,
    parameter coord_t END   = 16'sd639
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    coord_t count_q;
    coord_t count_d;

    // The wrap flag marks the enabled step that reloads START, so it is only high when en is.
    assign wrap  = en && (count_q == END);
    assign count = count_q;

    // Next position: step by one when enabled, reload START after the last position.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? START : count_q + 16'sd1;
        end
    end

    // Position register; reset parks the counter at START without raising wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= START;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mp3_display_timing.sv
// Raster timing generator feeding signed pixel coordinates to the mp3_display colouriser.
// Sync, data-enable and strobes are decoded from next-state coordinates and registered,
// so they line up with o_x/o_y on the same clock.
module mp3_display_timing
    import mp3_display_pkg::*;
#(
    parameter int H_RES  = TIMING_H_RES,
    parameter int H_FP   = TIMING_H_FP,
    parameter int H_SYNC = TIMING_H_SYNC,
    parameter int H_BP   = TIMING_H_BP,
    parameter int V_RES  = TIMING_V_RES,
    parameter int V_FP   = TIMING_V_FP,
    parameter int V_SYNC = TIMING_V_SYNC,
    parameter int V_BP   = TIMING_V_BP,
    parameter bit H_POL  = TIMING_H_POL,
    parameter bit V_POL  = TIMING_V_POL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pix_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_line,
    output logic        o_frame
);

    if (!(span_ok(H_RES, H_FP, H_SYNC, H_BP) && span_ok(V_RES, V_FP, V_SYNC, V_BP))) begin : g_bad_timing
        $error("mp3_display_timing: timing parameters must be positive and each span below 32768");
    end

    localparam coord_t H_STA  = span_start(H_FP, H_SYNC, H_BP);
    localparam coord_t V_STA  = span_start(V_FP, V_SYNC, V_BP);
    localparam coord_t H_END  = coord_t'(H_RES - 1);
    localparam coord_t V_END  = coord_t'(V_RES - 1);
    localparam coord_t HS_BEG = coord_t'(-(H_SYNC + H_BP));
    localparam coord_t HS_END = coord_t'(-(H_BP + 1));
    localparam coord_t VS_BEG = coord_t'(-(V_SYNC + V_BP));
    localparam coord_t VS_END = coord_t'(-(V_BP + 1));

    coord_t x_cnt;
    coord_t y_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_en;

    coord_t x_next;
    coord_t y_next;

    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic de_d, de_q;
    logic line_d, line_q;
    logic frame_d, frame_q;

    // Rows only advance on the pixel step that finishes a line.
    assign v_en = i_pix_en & h_wrap;

    mp3_span_counter #(
        .START (H_STA),
        .END   (H_END)
    ) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (i_pix_en),
        .count (x_cnt),
        .wrap  (h_wrap)
    );

    mp3_span_counter #(
        .START (V_STA),
        .END   (V_END)
    ) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (v_en),
        .count (y_cnt),
        .wrap  (v_wrap)
    );

    // Decode sync, DE and strobes from where the counters land on this edge.
    always_comb begin
        x_next = x_cnt;
        y_next = y_cnt;
        if (i_pix_en) begin
            x_next = h_wrap ? H_STA : x_cnt + 16'sd1;
        end
        if (v_en) begin
            y_next = v_wrap ? V_STA : y_cnt + 16'sd1;
        end
        hsync_d = ((x_next >= HS_BEG) && (x_next <= HS_END)) ? H_POL : ~H_POL;
        vsync_d = ((y_next >= VS_BEG) && (y_next <= VS_END)) ? V_POL : ~V_POL;
        de_d    = !x_next[15] && !y_next[15];
        line_d  = h_wrap;
        frame_d = v_wrap;
    end

    // Output registers; reset leaves syncs inactive and suppresses any strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign o_x     = x_cnt;
    assign o_y     = y_cnt;
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;
    assign o_de    = de_q;
    assign o_line  = line_q;
    assign o_frame = frame_q;

endmodule
